cast_gather_arbiter: RTL and testbench

- Shares the tile's single cast_gather output link between two flit sources: port 0 is the local cast stream and port 1 is the gather stream.
- Wormhole, packet-level arbiter. A grant is taken on a head flit and held until the tail flit, with round-robin between packets.
- Sits between the tile core and the cast_gather_data_o / cast_gather_valid_o / cast_gather_ready_i channel. It has one registered output stage.

---
 rtl/cast_gather_arbiter.sv | 166 ++++++++++++++++
 tb/tb_cast_gather_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cast_gather_arbiter.sv
// Two-input wormhole arbiter for the tile's cast_gather link: packet-level
// round-robin lock from head to tail, one registered output stage.
// Optional counters under `define CAST_GATHER_ARB_STATS_EN.
module cast_gather_arbiter #(
  parameter int DW = 32,
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in0_data_i,
  input  logic          in0_valid_i,
  output logic          in0_ready_o,
  input  logic [DW-1:0] in1_data_i,
  input  logic          in1_valid_i,
  output logic          in1_ready_o,
  output logic [DW-1:0] out_data_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [1:0]    grant_o,
  output logic          err_o
`ifdef CAST_GATHER_ARB_STATS_EN
  ,
  output logic [15:0]   pkt_cnt0_o,
  output logic [15:0]   pkt_cnt1_o,
  output logic [15:0]   stall_cnt_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOCK0, S_LOCK1} state_t;

  localparam logic [TW-1:0] T_BODY = TW'(0);
  localparam logic [TW-1:0] T_HEAD = TW'(1);
  localparam logic [TW-1:0] T_TAIL = TW'(2);
  localparam logic [TW-1:0] T_HT   = TW'(3);

  state_t        state_q, state_d;
  logic          rr_q, rr_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_vld_q, out_vld_d;
  logic          err_q, err_d;

  logic [TW-1:0] typ0, typ1, sel_typ;
  logic [DW-1:0] sel_data;
  logic          head0, head1, cand0, cand1, any_cand, win1;
  logic          adv, rdy0, rdy1, acc0, acc1, acc, fwd;

  assign typ0     = in0_data_i[DW-1 -: TW];
  assign typ1     = in1_data_i[DW-1 -: TW];
  assign head0    = (typ0 == T_HEAD) || (typ0 == T_HT);
  assign head1    = (typ1 == T_HEAD) || (typ1 == T_HT);
  assign cand0    = in0_valid_i && head0;
  assign cand1    = in1_valid_i && head1;
  assign any_cand = cand0 || cand1;
  assign win1     = cand1 && (!cand0 || rr_q);
  assign adv      = !out_vld_q || out_ready_i;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_q       <= 1'b0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      out_data_q <= out_data_d;
      out_vld_q  <= out_vld_d;
      err_q      <= err_d;
    end
  end

  // Output / handshake decode
  always_comb begin
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_cand) begin
          if (win1) rdy1 = adv;
          else      rdy0 = adv;
        end else if (in0_valid_i) begin
          rdy0 = 1'b1;  // stray body/tail: sink it, nothing reaches the output
        end else if (in1_valid_i) begin
          rdy1 = 1'b1;
        end
      end
      S_LOCK0: rdy0 = adv;
      S_LOCK1: rdy1 = adv;
      default: ;
    endcase
    if (rst) begin
      rdy0 = 1'b0;
      rdy1 = 1'b0;
    end
  end

  assign acc0     = rdy0 && in0_valid_i;
  assign acc1     = rdy1 && in1_valid_i;
  assign acc      = acc0 || acc1;
  assign fwd      = acc && ((state_q != S_IDLE) || any_cand);
  assign sel_data = acc1 ? in1_data_i : in0_data_i;
  assign sel_typ  = acc1 ? typ1 : typ0;

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    out_data_d = out_data_q;
    out_vld_d  = out_vld_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (fwd) begin
          rr_d = !acc1;
          if (sel_typ == T_HEAD) state_d = acc1 ? S_LOCK1 : S_LOCK0;
        end
        if (acc && !fwd) err_d = 1'b1;
      end
      S_LOCK0, S_LOCK1: begin
        if (fwd && (sel_typ == T_TAIL)) state_d = S_IDLE;
        if (fwd && ((sel_typ == T_HEAD) || (sel_typ == T_HT))) err_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (adv) begin
      out_vld_d = fwd;
      if (fwd) out_data_d = sel_data;
    end
  end

  assign in0_ready_o = rdy0;
  assign in1_ready_o = rdy1;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_vld_q;
  assign err_o       = err_q;
  assign grant_o     = {state_q == S_LOCK1, state_q == S_LOCK0};

`ifdef CAST_GATHER_ARB_STATS_EN
  logic [15:0] pkt0_q, pkt1_q, stall_q;
  logic        is_end;

  assign is_end = (sel_typ == T_TAIL) || (sel_typ == T_HT);

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt0_q  <= '0;
      pkt1_q  <= '0;
      stall_q <= '0;
    end else begin
      if (fwd && is_end && acc0 && (pkt0_q != 16'hFFFF)) pkt0_q <= pkt0_q + 16'd1;
      if (fwd && is_end && acc1 && (pkt1_q != 16'hFFFF)) pkt1_q <= pkt1_q + 16'd1;
      if (out_vld_q && !out_ready_i && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
    end
  end

  assign pkt_cnt0_o  = pkt0_q;
  assign pkt_cnt1_o  = pkt1_q;
  assign stall_cnt_o = stall_q;
`else
  logic unused_body;
  assign unused_body = (T_BODY == TW'(0));
`endif

endmodule

// File: tb/tb_cast_gather_arbiter.sv
// Scoreboard bench for cast_gather_arbiter: directed packets, expected
// flits queued at issue and checked by an independent output monitor.
module tb_cast_gather_arbiter;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in0_data_i, in1_data_i, out_data_o;
  logic          in0_valid_i, in0_ready_o, in1_valid_i, in1_ready_o;
  logic          out_valid_o, out_ready_i, err_o;
  logic [1:0]    grant_o;
`ifdef CAST_GATHER_ARB_STATS_EN
  logic [15:0]   pkt_cnt0_o, pkt_cnt1_o, stall_cnt_o;
`endif

  cast_gather_arbiter #(.DW(DW), .TW(2)) dut (
    .clk(clk), .rst(rst),
    .in0_data_i(in0_data_i), .in0_valid_i(in0_valid_i), .in0_ready_o(in0_ready_o),
    .in1_data_i(in1_data_i), .in1_valid_i(in1_valid_i), .in1_ready_o(in1_ready_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .grant_o(grant_o), .err_o(err_o)
`ifdef CAST_GATHER_ARB_STATS_EN
    , .pkt_cnt0_o(pkt_cnt0_o), .pkt_cnt1_o(pkt_cnt1_o), .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] src0[$], src1[$], expq[$];
  logic [1:0]    glog[$];
  logic [1:0]    last_g;
  int            vectors = 0;
  int            miscompares = 0;
  bit            a0, a1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    src0.delete(); src1.delete(); expq.delete();
    tick(1);
    rst = 1'b0;
    glog.delete();
    last_g = 2'b00;
  endtask

  task automatic drain();
    int n = 0;
    while ((expq.size() != 0 || src0.size() != 0 || src1.size() != 0) && n < 200) begin
      tick(1); n++;
    end
    chk("drain_timeout", (n >= 200) ? 32'd1 : 32'd0, 32'd0);
    tick(2);
  endtask

  // Source drivers: hold the queue head until its handshake is seen
  initial begin
    in0_valid_i = 1'b0; in0_data_i = '0;
    forever begin
      @(negedge clk); a0 = in0_valid_i && in0_ready_o && !rst;
      @(posedge clk); #1;
      if (a0 && src0.size() > 0) void'(src0.pop_front());
      if (src0.size() > 0) begin in0_valid_i = 1'b1; in0_data_i = src0[0]; end
      else begin in0_valid_i = 1'b0; in0_data_i = '0; end
    end
  end

  initial begin
    in1_valid_i = 1'b0; in1_data_i = '0;
    forever begin
      @(negedge clk); a1 = in1_valid_i && in1_ready_o && !rst;
      @(posedge clk); #1;
      if (a1 && src1.size() > 0) void'(src1.pop_front());
      if (src1.size() > 0) begin in1_valid_i = 1'b1; in1_data_i = src1[0]; end
      else begin in1_valid_i = 1'b0; in1_data_i = '0; end
    end
  end

  // Output monitor
  initial begin
    last_g = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid_o && out_ready_i) begin
          if (expq.size() == 0) chk("unexpected_flit", out_data_o, 32'hxxxxxxxx);
          else chk("out_data", out_data_o, expq.pop_front());
        end
        if (grant_o == 2'b01) chk("in1_ready_in_lock0", {31'd0, in1_ready_o}, 32'd0);
        if (grant_o == 2'b10) chk("in0_ready_in_lock1", {31'd0, in0_ready_o}, 32'd0);
        if (grant_o != last_g && grant_o != 2'b00) glog.push_back(grant_o);
        last_g = grant_o;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1; out_ready_i = 1'b1;
    tick(3);
    chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_out_data",  out_data_o, 32'd0);
    chk("rst_grant",     {30'd0, grant_o}, 32'd0);
    chk("rst_err",       {31'd0, err_o}, 32'd0);
    chk("rst_ready",     {30'd0, in1_ready_o, in0_ready_o}, 32'd0);
    rst = 1'b0;
    last_g = 2'b00;
    tick(1);

    // Single headtail on in0
    src0.push_back(32'hC000_00AA); expq.push_back(32'hC000_00AA);
    tick(1);
    @(negedge clk);
    chk("t1_in0_ready", {31'd0, in0_ready_o}, 32'd1);
    tick(1);
    chk("t1_out_valid", {31'd0, out_valid_o}, 32'd1);
    chk("t1_out_data",  out_data_o, 32'hC000_00AA);
    chk("t1_grant",     {30'd0, grant_o}, 32'd0);
    drain();
    // rr now prefers in1
    src0.push_back(32'hC000_00B0); src1.push_back(32'hC000_00B1);
    expq.push_back(32'hC000_00B1); expq.push_back(32'hC000_00B0);
    drain();

    // Two heads at once after reset
    do_reset();
    src0.push_back(32'h4000_0010); src0.push_back(32'h0000_0011);
    src0.push_back(32'h0000_0012); src0.push_back(32'h8000_0013);
    src1.push_back(32'h4000_0020); src1.push_back(32'h8000_0021);
    foreach (src0[i]) expq.push_back(src0[i]);
    foreach (src1[i]) expq.push_back(src1[i]);
    drain();
    chk("t2_grant_count", glog.size(), 32'd2);
    if (glog.size() == 2) begin
      chk("t2_grant_first",  {30'd0, glog[0]}, 32'd1);
      chk("t2_grant_second", {30'd0, glog[1]}, 32'd2);
    end

    // Back-to-back headtails on both inputs
    do_reset();
    for (int i = 0; i < 4; i++) begin
      src0.push_back(32'hC000_0030 + i); src1.push_back(32'hC000_0130 + i);
      expq.push_back(32'hC000_0030 + i); expq.push_back(32'hC000_0130 + i);
    end
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid_o) cnt++;
    end
    chk("t3_flits_in_9", cnt, 32'd8);
    drain();

    // Downstream stall mid-packet in LOCK0
    do_reset();
    src0.push_back(32'h4000_0040); src0.push_back(32'h0000_0041);
    src0.push_back(32'h0000_0042); src0.push_back(32'h0000_0043);
    src0.push_back(32'h8000_0044);
    foreach (src0[i]) expq.push_back(src0[i]);
    tick(2);
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_hold_data",  out_data_o, 32'h4000_0040);
      chk("t4_hold_valid", {31'd0, out_valid_o}, 32'd1);
      chk("t4_in0_ready",  {31'd0, in0_ready_o}, 32'd0);
      chk("t4_grant",      {30'd0, grant_o}, 32'd1);
    end
    tick(1);
    out_ready_i = 1'b1;
    drain();

    // Stray body on in1 while idle
    do_reset();
    src1.push_back(32'h0000_0055);
    tick(1);
    @(negedge clk);
    chk("t5_in1_ready", {31'd0, in1_ready_o}, 32'd1);
    tick(1);
    chk("t5_err",       {31'd0, err_o}, 32'd1);
    chk("t5_no_output", {31'd0, out_valid_o}, 32'd0);
    src0.push_back(32'hC000_0056); expq.push_back(32'hC000_0056);
    drain();
    chk("t5_err_sticky", {31'd0, err_o}, 32'd1);

    // Reset while locked to in1 with a flit held
    do_reset();
    chk("t6_err_cleared", {31'd0, err_o}, 32'd0);
    out_ready_i = 1'b0;
    src1.push_back(32'h4000_0060); src1.push_back(32'h0000_0061);
    tick(2);
    chk("t6_grant_lock1", {30'd0, grant_o}, 32'd2);
    chk("t6_held_valid",  {31'd0, out_valid_o}, 32'd1);
    rst = 1'b1;
    tick(1);
    chk("t6_rst_valid", {31'd0, out_valid_o}, 32'd0);
    chk("t6_rst_grant", {30'd0, grant_o}, 32'd0);
    chk("t6_rst_ready", {31'd0, in1_ready_o}, 32'd0);
    src0.delete(); src1.delete(); expq.delete();
    tick(1);
    rst = 1'b0; out_ready_i = 1'b1; last_g = 2'b00;
    src0.push_back(32'h4000_0070); src0.push_back(32'h8000_0071);
    expq.push_back(32'h4000_0070); expq.push_back(32'h8000_0071);
    tick(2);
    chk("t6_new_grant", {30'd0, grant_o}, 32'd1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
